// File: rtl/twos_pkg.sv
// Shared types and constants for the serial two's-complement datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package twos_pkg;

    // Serializer control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Word length shared by the serializer, the complementer and the
    // downstream deserializer, so every stage agrees on word boundaries.
    localparam int DEFAULT_WIDTH = 8;

endpackage : twos_pkg

// File: rtl/bit_counter.sv
// Bit-position counter for serial word framing; flags the final bit of a word.
// Latency: count and tc are registered and update one edge after clr/en.
// Backpressure: none; the counter follows clr/en unconditionally.
//
// Ports: clk/rst (async active-high), clr (sync load zero, wins over en),
//        en (increment), cnt (current bit index), tc (cnt == WIDTH-1).
module bit_counter
    import twos_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    output logic [$clog2(WIDTH)-1:0]   cnt,
    output logic                       tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Users clear at terminal count, so the counter never has to wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == CW'(WIDTH - 1));

endmodule : bit_counter

// File: rtl/twos_serializer.sv
// Parallel-to-serial front end: shifts a WIDTH-bit word out LSB first on i,
// with r marking bit 0 and last marking bit WIDTH-1.
// Latency: accept at edge k puts bit 0 on i from edge k; WIDTH cycles per word.
// Backpressure: din_ready is high in IDLE and during the last bit of a word,
// so back-to-back words stream with no gap.
//
// Ports: t_clk, rst (async active-high), din/din_valid/din_ready handshake,
//        i (serial bit), r (word start), last (final bit), busy (shifting).
module twos_serializer
    import twos_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             t_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             i,
    output logic             r,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_d;
    state_t           state_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] sreg_q;

    logic [CW-1:0]    cnt;
    logic             tc;
    logic             shifting;
    logic             accept;
    logic             cnt_clr;

    assign shifting = (state_q == ST_SHIFT);

    // Everything below is decoded from flops only; din/din_valid never
    // reach an output combinationally.
    assign din_ready = !shifting || tc;
    assign busy      = shifting;
    assign i         = shifting && sreg_q[0];
    assign r         = shifting && (cnt == '0);
    assign last      = shifting && tc;

    assign accept    = din_valid && din_ready;

    // The counter restarts from zero whether the next cycle begins a new
    // word or falls back to IDLE; in IDLE it is simply held at zero.
    assign cnt_clr   = !shifting || tc;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk (t_clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (shifting),
        .cnt (cnt),
        .tc  (tc)
    );

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    sreg_d  = din;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    // Only reachable on the final bit: reload in place.
                    sreg_d = din;
                end else begin
                    sreg_d = sreg_q >> 1;
                    if (tc) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge t_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule : twos_serializer

// File: tb/tb_twos_serializer.sv
// Directed bench for twos_serializer (WIDTH=8 and WIDTH=4 instances) with a
// behavioural serial two's-complement stage on the 8-bit output.
module tb_twos_serializer;
    import twos_pkg::*;

    logic       t_clk = 1'b0;
    logic       rst;

    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       i;
    logic       r;
    logic       last;
    logic       busy;

    logic [3:0] din4;
    logic       din_valid4;
    logic       din_ready4;
    logic       i4;
    logic       r4;
    logic       last4;
    logic       busy4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 t_clk = ~t_clk;

    twos_serializer #(.WIDTH(DEFAULT_WIDTH)) dut (
        .t_clk     (t_clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .i         (i),
        .r         (r),
        .last      (last),
        .busy      (busy)
    );

    twos_serializer #(.WIDTH(4)) dut4 (
        .t_clk     (t_clk),
        .rst       (rst),
        .din       (din4),
        .din_valid (din_valid4),
        .din_ready (din_ready4),
        .i         (i4),
        .r         (r4),
        .last      (last4),
        .busy      (busy4)
    );

    // Serial two's-complement stage: copy up to and including the first 1,
    // invert afterwards; r restarts it on every word.
    bit         collect = 1'b0;
    logic       seen    = 1'b0;
    logic       yb;
    logic [7:0] ycol    = '0;
    logic [7:0] yq[$];

    always @(negedge t_clk) begin
        if (collect && busy) begin
            yb   = r ? i : (seen ? ~i : i);
            seen = r ? i : (seen | i);
            ycol = {yb, ycol[7:1]};
            if (last) yq.push_back(ycol);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge t_clk);
        #1;
    endtask

    // Streams nw words packed LSB-word-first in s. With scramble set, din
    // carries junk while the DUT is busy and the next real word only in the
    // last-bit cycle.
    task automatic run_stream(input string tag, input logic [31:0] s,
                              input int nw, input bit scramble);
        din       = s[7:0];
        din_valid = 1'b1;
        step();
        for (int n = 0; n < 8 * nw; n++) begin
            int w = n / 8;
            int b = n % 8;
            check($sformatf("%s_i[%0d]", tag, n),     32'(i),         32'(s[n]));
            check($sformatf("%s_r[%0d]", tag, n),     32'(r),         32'(b == 0));
            check($sformatf("%s_last[%0d]", tag, n),  32'(last),      32'(b == 7));
            check($sformatf("%s_rdy[%0d]", tag, n),   32'(din_ready), 32'(b == 7));
            check($sformatf("%s_busy[%0d]", tag, n),  32'(busy),      32'd1);
            if (w + 1 < nw) begin
                if (b == 7)        din = s[(w + 1) * 8 +: 8];
                else if (scramble) din = 8'h55 ^ 8'(n);
                else               din = s[(w + 1) * 8 +: 8];
            end else begin
                din_valid = 1'b0;
            end
            step();
        end
        check({tag, "_idle_busy"}, 32'(busy),      32'd0);
        check({tag, "_idle_rdy"},  32'(din_ready), 32'd1);
        check({tag, "_idle_i"},    32'(i),         32'd0);
    endtask

    logic [7:0] yexp [3];
    logic [3:0] exp4;

    initial begin
        rst        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din4       = '0;
        din_valid4 = 1'b0;
        #2;
        check("rst_i",    32'(i),          32'd0);
        check("rst_r",    32'(r),          32'd0);
        check("rst_last", 32'(last),       32'd0);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_rdy",  32'(din_ready),  32'd1);
        check("rst_rdy4", 32'(din_ready4), 32'd1);
        step();
        rst = 1'b0;

        // Single word 0xB4 -> 0,0,1,0,1,1,0,1
        run_stream("single", 32'h0000_00B4, 1, 1'b0);

        // Back-to-back 0x01 then 0xFF
        run_stream("b2b", 32'h0000_FF01, 2, 1'b0);

        // Junk on din mid-word; only 0xC3 from the last cycle is sent
        run_stream("midword", 32'h0000_C33C, 2, 1'b1);

        // Reset at bit 3 of 0xAA
        din       = 8'hAA;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        step();
        check("aa_bit3_i",    32'(i),    32'd1);
        check("aa_bit3_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_i",    32'(i),         32'd0);
        check("arst_r",    32'(r),         32'd0);
        check("arst_last", 32'(last),      32'd0);
        check("arst_busy", 32'(busy),      32'd0);
        check("arst_rdy",  32'(din_ready), 32'd1);
        step();
        rst = 1'b0;
        run_stream("post_rst", 32'h0000_000F, 1, 1'b0);

        // End to end through the complementer model
        yexp[0] = 8'hFA;
        yexp[1] = 8'h00;
        yexp[2] = 8'h80;
        yq.delete();
        collect = 1'b1;
        run_stream("e2e", 32'h0080_0006, 3, 1'b0);
        collect = 1'b0;
        check("e2e_nwords", 32'(yq.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("e2e_y[%0d]", k),
                  (k < yq.size()) ? 32'(yq[k]) : 32'hxxxx_xxxx, 32'(yexp[k]));
        end

        // WIDTH=4, 0xA -> 0,1,0,1
        exp4       = 4'hA;
        din4       = exp4;
        din_valid4 = 1'b1;
        step();
        din_valid4 = 1'b0;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("w4_i[%0d]", n),    32'(i4),         32'(exp4[n]));
            check($sformatf("w4_r[%0d]", n),    32'(r4),         32'(n == 0));
            check($sformatf("w4_last[%0d]", n), 32'(last4),      32'(n == 3));
            check($sformatf("w4_rdy[%0d]", n),  32'(din_ready4), 32'(n == 3));
            step();
        end
        check("w4_idle_busy", 32'(busy4),      32'd0);
        check("w4_idle_rdy",  32'(din_ready4), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_twos_serializer

// File: doc/twos_serializer.md
# twos_serializer

Parallel-to-serial front end for the serial two's-complement stage. Accepts a `WIDTH`-bit word over a valid/ready handshake and shifts it out LSB first, one bit per `t_clk` cycle, on `i`. It drives the word-start strobe `r` high during bit 0 of every word, so the downstream complementer restarts its copy/invert state on each word boundary. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `t_clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `din`  input  WIDTH  parallel word; sampled only on handshake.
- `din_valid`  input  1  upstream has a word on `din`.
- `din_ready`  output  1  block can accept a word this cycle.
- `i`  output  1  serial data bit to the complementer, LSB first.
- `r`  output  1  word-start strobe; high only while `i` carries bit 0.
- `last`  output  1  high only while `i` carries bit `WIDTH-1`.
- `busy`  output  1  a word is currently being shifted out.

## Operation
- Handshake: a word is accepted on a rising edge where `din_valid && din_ready`. When `din_ready` is low, `din` is ignored. Upstream holds `din` stable until accepted.
- States:
  - IDLE: `din_ready=1`, `busy=0`, `i=0`, `r=0`, `last=0`. On accept, go to SHIFT; load shift register with `din`; `cnt=0`.
  - SHIFT: `busy=1`, `i=sreg[0]`, `r=(cnt==0)`, `last=(cnt==WIDTH-1)`. Each edge: shift right and increment `cnt`.
  - `din_ready` in SHIFT equals `last`.
  - At the `cnt==WIDTH-1` edge with accept: reload `sreg` with `din`, `cnt=0`, stay in SHIFT.
  - At the `cnt==WIDTH-1` edge without accept: go to IDLE.
- `cnt` is `$clog2(WIDTH)` bits wide. It never exceeds `WIDTH-1`; no wrap is used.
- All outputs are decoded from registered state, so no combinational path exists from `din`/`din_valid` to any output.
- Reset (any time, including mid-word): state IDLE; `sreg`, `cnt` cleared; outputs `i=0`, `r=0`, `last=0`, `busy=0`, `din_ready=1`, all asynchronously. The partially sent word is dropped, not resumed.

## Timing
- Latency: accept at edge k puts bit 0 on `i` with `r=1` from edge k to edge k+1. Bit n is valid between edges k+n and k+n+1.
- A word occupies exactly `WIDTH` consecutive cycles. `r` and `last` are each one-cycle pulses per word.
- Streaming: a word accepted in the `last` cycle begins at the very next edge. Sustained throughput is one bit per clock with zero gap cycles.
- Downstream samples `i`/`r` on the edge that ends each bit cycle. `r` is high together with bit 0 on that same edge, which is what the complementer requires.
- Reset release: the first accept is possible on the first rising edge after `rst` deasserts.

## Structure
- Shared package `twos_pkg`:
  - state enum `{ST_IDLE, ST_SHIFT}`
  - `DEFAULT_WIDTH = 8`
  - the same constant used by the complementer bench for word length
- One natural sub-module: `bit_counter`. It is a `$clog2(WIDTH)`-bit up counter with sync load-zero, enable, and a terminal-count flag `tc = (cnt==WIDTH-1)`. It drives `last`/`din_ready` and is reused by the downstream deserializer.
- The top level holds the FSM, the shift register, and the output decode.

## Test plan
- Single word, `WIDTH=8`, `din=8'hB4` accepted at edge 0.
  - `i` = 0,0,1,0,1,1,0,1 over the next 8 cycles.
  - `r` high only in cycle 1; `last` high only in cycle 8.
  - Then IDLE with `din_ready=1`, `busy=0`.
- Back-to-back, `din_valid` held high with `8'h01` then `8'hFF`.
  - 16 contiguous bits: 1,0×7,1×8.
  - `r` pulses at bits 0 and 8; `din_ready` high only in IDLE and in each `last` cycle.
- `din_valid` asserted mid-word with changing `din`: it is not captured until the `last` cycle, and only the value present there is sent.
- `rst` pulsed at bit 3 of `8'hAA`.
  - All outputs go to reset values immediately, without waiting for a clock.
  - After release, `8'h0F` streams 1,1,1,1,0,0,0,0 with `r` on bit 0.
- End-to-end with the complementer, words `8'h06`, `8'h00`, `8'h80`.
  - Collected `y` words are `8'hFA`, `8'h00`, `8'h80`.
  - No state carries across words, since `r` resets it each word.
- `WIDTH=4`, `din=4'hA`: `i` = 0,1,0,1; `last` in the 4th bit cycle; `cnt` is 2 bits.
